// File: rtl/pb_group_ctrl.sv
// pb_group_ctrl: synchronises 4 push buttons and 16 slide switches, debounces
// and edge-detects the buttons, and keeps one blank flag per 4-LED group.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   btn_raw     raw bouncy push buttons, bit i controls LED group i
//   sw_raw      raw slide switches
//   sw_sync     switches after a 2-flop synchroniser
//   btn_level   debounced button levels
//   btn_press   one-cycle pulse on each debounced 0->1 transition
//   group_blank per-group blank flag, 1 = group forced off
module pb_group_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit TOGGLE_MODE     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_raw,
    input  logic [15:0] sw_raw,
    output logic [15:0] sw_sync,
    output logic [3:0]  btn_level,
    output logic [3:0]  btn_press,
    output logic [3:0]  group_blank
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [19:0]      sync1;
    logic [19:0]      sync2;
    logic [3:0]       btn_s;
    logic [CNT_W-1:0] cnt    [4];
    logic [CNT_W-1:0] cnt_nx [4];
    logic [3:0]       level_nx;
    logic [3:0]       press_nx;
    logic [3:0]       blank_nx;

    assign btn_s   = sync2[3:0];
    assign sw_sync = sync2[19:4];

    // A counter only runs while the synced button disagrees with the
    // accepted level; any agreement clears it, so it can never wrap.
    always_comb begin
        level_nx = btn_level;
        press_nx = '0;
        blank_nx = group_blank;
        for (int i = 0; i < 4; i++) begin
            cnt_nx[i] = '0;
            if (btn_s[i] != btn_level[i]) begin
                if (cnt[i] == LAST) begin
                    level_nx[i] = btn_s[i];
                    press_nx[i] = btn_s[i];
                end else begin
                    cnt_nx[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        if (TOGGLE_MODE) begin
            blank_nx = group_blank ^ press_nx;
        end else begin
            blank_nx = level_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            group_blank <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= {sw_raw, btn_raw};
            sync2       <= sync1;
            btn_level   <= level_nx;
            btn_press   <= press_nx;
            group_blank <= blank_nx;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_pb_group_ctrl.sv
// tb_pb_group_ctrl: directed and randomized checks of pb_group_ctrl against
// a cycle-level reference model; three instances cover N=4/toggle, N=4/level, N=1.
module tb_pb_group_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  btn_raw = 4'hF;
    logic [15:0] sw_raw = 16'hFFFF;

    logic [15:0] sw_o  [3];
    logic [3:0]  lvl_o [3];
    logic [3:0]  prs_o [3];
    logic [3:0]  blk_o [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pb_group_ctrl #(.DEBOUNCE_CYCLES(4), .TOGGLE_MODE(1'b1)) u_t4 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .sw_sync(sw_o[0]), .btn_level(lvl_o[0]),
        .btn_press(prs_o[0]), .group_blank(blk_o[0])
    );

    pb_group_ctrl #(.DEBOUNCE_CYCLES(4), .TOGGLE_MODE(1'b0)) u_l4 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .sw_sync(sw_o[1]), .btn_level(lvl_o[1]),
        .btn_press(prs_o[1]), .group_blank(blk_o[1])
    );

    pb_group_ctrl #(.DEBOUNCE_CYCLES(1), .TOGGLE_MODE(1'b1)) u_t1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .sw_sync(sw_o[2]), .btn_level(lvl_o[2]),
        .btn_press(prs_o[2]), .group_blank(blk_o[2])
    );

    // Reference model: raw inputs reach the logic two edges late; a level is
    // accepted after N consecutive edges of disagreement.
    logic [19:0] d1 = '0;
    logic [19:0] d2 = '0;
    int          run  [3][4];
    logic [3:0]  mlvl [3];
    logic [3:0]  mprs [3];
    logic [3:0]  mblk [3];

    function automatic int nof(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit tm(input int k);
        return k != 1;
    endfunction

    task automatic model_reset();
        d1 = '0;
        d2 = '0;
        for (int k = 0; k < 3; k++) begin
            mlvl[k] = '0;
            mprs[k] = '0;
            mblk[k] = '0;
            for (int i = 0; i < 4; i++) run[k][i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] s;
        s = d2[3:0];
        for (int k = 0; k < 3; k++) begin
            mprs[k] = '0;
            for (int i = 0; i < 4; i++) begin
                if (s[i] != mlvl[k][i]) run[k][i]++;
                else run[k][i] = 0;
                if (run[k][i] == nof(k)) begin
                    mlvl[k][i] = s[i];
                    run[k][i] = 0;
                    if (s[i]) begin
                        mprs[k][i] = 1'b1;
                        if (tm(k)) mblk[k][i] = ~mblk[k][i];
                    end
                end
            end
            if (!tm(k)) mblk[k] = mlvl[k];
        end
        d2 = d1;
        d1 = {sw_raw, btn_raw};
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m_sw%0d", k), 32'(sw_o[k]), 32'(d2[19:4]));
            chk($sformatf("m_lvl%0d", k), 32'(lvl_o[k]), 32'(mlvl[k]));
            chk($sformatf("m_prs%0d", k), 32'(prs_o[k]), 32'(mprs[k]));
            chk($sformatf("m_blk%0d", k), 32'(blk_o[k]), 32'(mblk[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    logic [3:0] acc;
    int hold [4];
    bit bounce [6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_async_out", {sw_o[k], lvl_o[k], prs_o[k], blk_o[k]}, 32'h0);
        end
        repeat (3) tick();
        chk("rst_clk_out", {sw_o[0], lvl_o[0], prs_o[0], blk_o[0]}, 32'h0);
        rst = 1'b0;
        btn_raw = 4'h0;
        sw_raw = 16'h0;
        repeat (3) tick();

        sw_raw = 16'hA5C3;
        tick();
        chk("sw_edge1", 32'(sw_o[0]), 32'h0);
        tick();
        chk("sw_edge2", 32'(sw_o[0]), 32'hA5C3);

        btn_raw = 4'b0001;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 2) chk("n1_lvl_e2", 32'(lvl_o[2][0]), 32'h0);
            if (t == 3) chk("n1_lvl_e3", 32'(lvl_o[2][0]), 32'h1);
            if (t == 5) chk("press_lvl_e5", 32'(lvl_o[0]), 32'h0);
        end
        chk("press_lvl_e6", 32'(lvl_o[0]), 32'h1);
        chk("press_pulse", 32'(prs_o[0]), 32'h1);
        chk("press_blank", 32'(blk_o[0]), 32'h1);
        tick();
        chk("press_pulse_end", 32'(prs_o[0]), 32'h0);
        btn_raw = 4'b0000;
        acc = '0;
        repeat (8) begin
            tick();
            acc |= prs_o[0];
        end
        chk("release_no_pulse", 32'(acc), 32'h0);
        chk("release_blank", 32'(blk_o[0]), 32'h1);
        btn_raw = 4'b0001;
        repeat (6) tick();
        chk("press2_blank", 32'(blk_o[0]), 32'h0);
        btn_raw = 4'b0000;
        repeat (8) tick();
        pulse_rst();
        tick();

        acc = '0;
        for (int j = 0; j < 6; j++) begin
            btn_raw[2] = bounce[j];
            tick();
            acc |= prs_o[0];
        end
        btn_raw[2] = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            acc |= prs_o[0];
        end
        chk("bounce_no_press", 32'(acc), 32'h0);
        tick();
        chk("bounce_press_e6", 32'(prs_o[0]), 32'h4);
        btn_raw = 4'b0000;
        repeat (8) tick();
        pulse_rst();
        tick();

        btn_raw = 4'b1010;
        repeat (6) tick();
        chk("simul_press", 32'(prs_o[0]), 32'hA);
        tick();
        chk("simul_blank", 32'(blk_o[0]), 32'hA);
        btn_raw = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_blank", 32'(blk_o[0]), 32'h0);
        chk("rst_mid_lvl", 32'(lvl_o[0]), 32'h0);
        #1 rst = 1'b0;
        tick();

        btn_raw = 4'b1000;
        repeat (5) tick();
        chk("lvl_mode_e5", 32'(blk_o[1]), 32'h0);
        tick();
        chk("lvl_mode_held", 32'(blk_o[1]), 32'h8);
        repeat (4) tick();
        chk("lvl_mode_still", 32'(blk_o[1]), 32'h8);
        btn_raw = 4'b0000;
        repeat (5) tick();
        chk("lvl_mode_rel_e5", 32'(blk_o[1]), 32'h8);
        tick();
        chk("lvl_mode_rel", 32'(blk_o[1]), 32'h0);

        btn_raw = 4'b1000;
        repeat (4) tick();
        pulse_rst();
        repeat (5) tick();
        chk("rst_cnt_e5", 32'(lvl_o[1][3]), 32'h0);
        tick();
        chk("rst_cnt_e6", 32'(lvl_o[1][3]), 32'h1);
        chk("rst_cnt_blank", 32'(blk_o[1]), 32'h8);
        btn_raw = 4'b0000;
        repeat (8) tick();

        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 9) < 6) hold[i] = $urandom_range(5, 14);
                    else hold[i] = $urandom_range(1, 3);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 7) == 0) sw_raw = 16'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_rst();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
